// File: rtl/cpu_pkg.sv
// Shared fetch-side types and sizing for the instruction queue.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_DW    = $bits(fetch_entry_t);

  // A pop request of 3 behaves as 2.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/iq_mem.sv
// Instruction queue storage: DEPTH x DW flops, two guarded write ports,
// two asynchronous read ports. Storage is deliberately not reset.
module iq_mem #(
  parameter int DEPTH = 8,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we1 && (waddr1 == AW'(i))) begin
        mem_q[i] <= wdata1;
      end else if (we0 && (waddr0 == AW'(i))) begin
        mem_q[i] <= wdata0;
      end
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: 2-wide push, 2-wide peek/pop, flush.
// Outputs are functions of registered head/tail/count only.
module inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH         = IQ_DEPTH,
  parameter int DW            = IQ_DW,
  parameter bit OVERPOP_CHECK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid0,
  input  logic          in_valid1,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  output logic          in_ready,
  output logic          out_valid0,
  output logic          out_valid1,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  input  logic [1:0]    out_pop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    pop_req, n_pop, n_push;
  logic          we0, we1;

  assign in_ready   = (count_q <= CW'(DEPTH - 2));
  assign out_valid0 = (count_q != '0);
  assign out_valid1 = (count_q >= CW'(2));

  always_comb begin
    pop_req = clamp_pop(out_pop);
    // count_q is below 2 whenever the request exceeds it, so its low bits suffice
    n_pop   = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;
    n_push  = 2'd0;
    if (in_ready && in_valid0) begin
      n_push = in_valid1 ? 2'd2 : 2'd1;
    end
    we0     = !flush && (n_push != 2'd0);
    we1     = !flush && (n_push == 2'd2);
    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_push);
    count_d = count_q + CW'(n_push) - CW'(n_pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  iq_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (tail_q),
    .wdata0 (in_data0),
    .we1    (we1),
    .waddr1 (tail_q + PW'(1)),
    .wdata1 (in_data1),
    .raddr0 (head_q),
    .raddr1 (head_q + PW'(1)),
    .rdata0 (out_data0),
    .rdata1 (out_data1)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (OVERPOP_CHECK && !rst && !flush) begin
      assert (CW'(pop_req) <= count_q)
        else $warning("inst_queue: over-pop req=%0d count=%0d", pop_req, count_q);
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue with a queue-based reference
// model; expected outputs go to a scoreboard checked by a separate monitor.
module tb_inst_queue;
  import cpu_pkg::*;

  localparam int DEPTH = IQ_DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [63:0]   in_data0 = '0, in_data1 = '0;
  logic [1:0]    out_pop = 2'd0;
  logic          in_ready, out_valid0, out_valid1;
  logic [63:0]   out_data0, out_data1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          v0, v1, rdy;
    logic [63:0] d0, d1;
  } snap_t;

  logic [63:0] model_q[$];
  snap_t       sb[$];

  inst_queue #(.DEPTH(DEPTH), .DW(64), .OVERPOP_CHECK(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid0  (in_valid0),
    .in_valid1  (in_valid1),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .in_ready   (in_ready),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_pop    (out_pop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the queue contents are the architectural state.
  task automatic model_step();
    int pre, np;
    if (rst || flush) begin
      model_q.delete();
      return;
    end
    pre = model_q.size();
    np  = (out_pop == 2'd3) ? 2 : int'(out_pop);
    if (np > pre) np = pre;
    repeat (np) void'(model_q.pop_front());
    if (pre <= DEPTH - 2 && in_valid0) begin
      model_q.push_back(in_data0);
      if (in_valid1) model_q.push_back(in_data1);
    end
  endtask

  function automatic snap_t expect_now();
    snap_t s;
    s.v0  = model_q.size() >= 1;
    s.v1  = model_q.size() >= 2;
    s.rdy = model_q.size() <= DEPTH - 2;
    s.d0  = s.v0 ? model_q[0] : 64'd0;
    s.d1  = s.v1 ? model_q[1] : 64'd0;
    return s;
  endfunction

  task automatic drive(input bit v0, input bit v1, input logic [63:0] a,
                       input logic [63:0] b, input logic [1:0] pop, input bit fl);
    in_valid0 = v0;
    in_valid1 = v1;
    in_data0  = a;
    in_data1  = b;
    out_pop   = pop;
    flush     = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    sb.push_back(expect_now());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 64'd0, 64'd0, 2'd0, 0);
    repeat (n) cycle();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    snap_t s;
    if (sb.size() > 0) begin
      s = sb.pop_front();
      chk("out_valid0", 64'(out_valid0), 64'(s.v0));
      chk("out_valid1", 64'(out_valid1), 64'(s.v1));
      chk("in_ready",   64'(in_ready),   64'(s.rdy));
      if (s.v0) chk("out_data0", out_data0, s.d0);
      if (s.v1) chk("out_data1", out_data1, s.d1);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid0", 64'(out_valid0), 64'd0);
    chk("reset_valid1", 64'(out_valid1), 64'd0);
    chk("reset_ready",  64'(in_ready),   64'd1);
    rst = 1'b0;
    idle(1);

    // 1: pair push becomes visible the next cycle
    drive(1, 1, 64'hA, 64'hB, 2'd0, 0); cycle();
    idle(1);

    // 2: fill to 7, dropped push, pop 2 then accept
    drive(1, 1, 64'h11, 64'h12, 2'd0, 0); cycle();
    drive(1, 1, 64'h13, 64'h14, 2'd0, 0); cycle();
    drive(1, 0, 64'h15, 64'h0,  2'd0, 0); cycle();
    drive(1, 0, 64'hC,  64'h0,  2'd0, 0); cycle();
    drive(1, 0, 64'hC,  64'h0,  2'd2, 0); cycle();
    drive(1, 0, 64'hC,  64'h0,  2'd0, 0); cycle();
    drive(0, 0, 64'h0,  64'h0,  2'd1, 1); cycle();

    // 3: steer head and tail to the last index, then a straddling pair write
    drive(1, 0, 64'h20, 64'h0, 2'd0, 0); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 64'h21 + 64'(i), 64'h0, 2'd1, 0); cycle();
    end
    drive(0, 0, 64'h0, 64'h0, 2'd1, 0); cycle();
    drive(1, 1, 64'hDEAD_0007, 64'hBEEF_0000, 2'd0, 0); cycle();
    drive(0, 0, 64'h0, 64'h0, 2'd1, 0); cycle();
    idle(1);

    // 4: push2/pop2 at count 4, then push1/pop2 at count 1 (clamped)
    drive(0, 0, 64'h0, 64'h0, 2'd1, 1); cycle();
    drive(1, 1, 64'h41, 64'h42, 2'd0, 0); cycle();
    drive(1, 1, 64'h43, 64'h44, 2'd0, 0); cycle();
    drive(1, 1, 64'h45, 64'h46, 2'd2, 0); cycle();
    drive(0, 0, 64'h0,  64'h0,  2'd3, 0); cycle();
    drive(0, 0, 64'h0,  64'h0,  2'd1, 0); cycle();
    drive(1, 0, 64'h47, 64'h0,  2'd2, 0); cycle();
    drive(0, 1, 64'h48, 64'h49, 2'd0, 0); cycle();

    // 5: flush at count 5 with push and pop in the same cycle
    drive(1, 1, 64'h51, 64'h52, 2'd0, 0); cycle();
    drive(1, 1, 64'h53, 64'h54, 2'd0, 0); cycle();
    drive(1, 1, 64'h55, 64'h56, 2'd2, 1); cycle();
    idle(1);

    // 6: asynchronous reset at count 6
    drive(1, 1, 64'h61, 64'h62, 2'd0, 0); cycle();
    drive(1, 1, 64'h63, 64'h64, 2'd0, 0); cycle();
    drive(1, 1, 64'h65, 64'h66, 2'd0, 0); cycle();
    drive(0, 0, 64'h0, 64'h0, 2'd0, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid0", 64'(out_valid0), 64'd0);
    chk("async_rst_ready",  64'(in_ready),   64'd1);
    model_q.delete();
    cycle();
    rst = 1'b0;
    drive(1, 0, 64'h6A, 64'h0, 2'd0, 0); cycle();
    idle(1);

    // Random traffic with fill / drain / mixed phases
    for (int i = 0; i < 1500; i++) begin
      int phase;
      bit v0, v1;
      logic [1:0] pop;
      phase = (i / 100) % 3;
      v0  = ($urandom_range(0, 3) != 0);
      v1  = v0 ? $urandom_range(0, 1) == 1 : ($urandom_range(0, 15) == 0);
      case (phase)
        0:       pop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        1:       pop = 2'($urandom_range(1, 3));
        default: pop = 2'($urandom_range(0, 3));
      endcase
      if (phase == 1 && $urandom_range(0, 1) == 0) v0 = 1'b0;
      drive(v0, v1 & (v0 | ($urandom_range(0, 1) == 1)), rnd64(), rnd64(), pop,
            $urandom_range(0, 63) == 0);
      cycle();
    end

    idle(2);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
